// File: rtl/iq_compact_ctrl.sv
// Compacting issue queue: oldest-first, 3-wide out-of-order issue from the head, holes squeezed out each edge.
// Latency: an accepted entry is visible on head_* the cycle after in_valid&in_ready; head_* is a direct register read.
// Backpressure: in_ready = count<DEPTH from registers only. Build option IQ_STALL_CNT_EN adds the stall counter.
module iq_compact_ctrl #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        in_ready,
  output logic [2:0]                  head_valid,
  output logic [3*DATA_W-1:0]         head_data,
  input  logic [2:0]                  issue,
  input  logic                        flush,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic [15:0]                 stall_cnt
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_n [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_n;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     cnt_n;
  logic [CW-1:0]     wr_idx;
  logic [2:0]        qual;
  logic [1:0]        removed;
  logic              acc;

  // Source view padded by 3 so every destination can look up to 3 places above itself.
  logic [DATA_W-1:0] data_x  [DEPTH+3];
  logic              keep_x  [DEPTH+3];
  logic [1:0]        shift_x [DEPTH+3];

  assign qual     = issue & valid_q[2:0];
  assign removed  = 2'(qual[0]) + 2'(qual[1]) + 2'(qual[2]);
  assign in_ready = (count_q < CW'(DEPTH));
  assign acc      = in_valid & in_ready & ~flush;
  assign wr_idx   = count_q - CW'(removed);
  assign cnt_n    = wr_idx + CW'(acc);

  for (genvar j = 0; j < DEPTH + 3; j++) begin : g_src
    if (j < DEPTH) begin : g_real
      assign data_x[j] = data_q[j];
      if (j < 3) begin : g_head
        assign keep_x[j] = valid_q[j] & ~qual[j];
      end else begin : g_body
        assign keep_x[j] = valid_q[j];
      end
      if (j == 0) begin : g_s0
        assign shift_x[j] = 2'd0;
      end else if (j == 1) begin : g_s1
        assign shift_x[j] = 2'(qual[0]);
      end else if (j == 2) begin : g_s2
        assign shift_x[j] = 2'(qual[0]) + 2'(qual[1]);
      end else begin : g_sn
        assign shift_x[j] = removed;
      end
    end else begin : g_pad
      assign data_x[j]  = '0;
      assign keep_x[j]  = 1'b0;
      assign shift_x[j] = 2'd0;
    end
  end

  // Each destination takes the unique survivor whose shift lands it here; the new entry goes on top.
  for (genvar i = 0; i < DEPTH; i++) begin : g_dst
    logic [DATA_W-1:0] d_nxt;
    always_comb begin
      d_nxt = data_q[i];
      if (keep_x[i+3] && shift_x[i+3] == 2'd3) d_nxt = data_x[i+3];
      if (keep_x[i+2] && shift_x[i+2] == 2'd2) d_nxt = data_x[i+2];
      if (keep_x[i+1] && shift_x[i+1] == 2'd1) d_nxt = data_x[i+1];
      if (keep_x[i]   && shift_x[i]   == 2'd0) d_nxt = data_x[i];
      if (acc && wr_idx == CW'(i))             d_nxt = in_data;
    end
    assign data_n[i]  = d_nxt;
    assign valid_n[i] = ~flush & (CW'(i) < cnt_n);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
      valid_q <= '0;
      count_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) data_q[k] <= data_n[k];
      valid_q <= valid_n;
      count_q <= flush ? '0 : cnt_n;
    end
  end

  assign head_valid = valid_q[2:0];
  assign head_data  = {data_q[2], data_q[1], data_q[0]};
  assign count      = count_q;

`ifdef IQ_STALL_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (flush) begin
      stall_q <= '0;
    end else if (in_valid && !in_ready && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_iq_compact_ctrl.sv
// Bench for iq_compact_ctrl: directed scenarios plus random traffic against a queue-based reference.
module tb_iq_compact_ctrl;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 16;
  localparam int CW     = $clog2(DEPTH+1);

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic [DATA_W-1:0]   in_data;
  logic                in_ready;
  logic [2:0]          head_valid;
  logic [3*DATA_W-1:0] head_data;
  logic [2:0]          issue;
  logic                flush;
  logic [CW-1:0]       count;
  logic [15:0]         stall_cnt;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] mq[$];
  int                mstall = 0;

  iq_compact_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .head_valid(head_valid), .head_data(head_data), .issue(issue), .flush(flush),
    .count(count), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [2:0] hv;
    hv = '0;
    for (int k = 0; k < 3; k++) if (k < mq.size()) hv[k] = 1'b1;
    chk({tag, "_count"}, count, mq.size());
    chk({tag, "_ready"}, in_ready, mq.size() < DEPTH);
    chk({tag, "_hvalid"}, head_valid, hv);
    for (int k = 0; k < 3; k++)
      if (k < mq.size()) chk({tag, "_hdata"}, head_data[k*DATA_W +: DATA_W], mq[k]);
`ifdef IQ_STALL_CNT_EN
    chk({tag, "_stall"}, stall_cnt, mstall);
`else
    chk({tag, "_stall"}, stall_cnt, 0);
`endif
  endtask

  // One clock of traffic: the reference applies the queue rules, then all outputs are compared.
  task automatic step(input string tag, input logic v, input logic [DATA_W-1:0] d,
                      input logic [2:0] iss, input logic fl);
    logic [DATA_W-1:0] nq[$];
    bit rdy;
    in_valid = v; in_data = d; issue = iss; flush = fl;
    rdy = (mq.size() < DEPTH);
    if (v && !rdy && mstall < 65535) mstall++;
    if (fl) begin
      mq.delete();
      mstall = 0;
    end else begin
      for (int k = 0; k < mq.size(); k++)
        if (!(k < 3 && iss[k])) nq.push_back(mq[k]);
      if (v && rdy) nq.push_back(d);
      mq = nq;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; issue = '0; flush = 1'b0;
    check_all(tag);
  endtask

  task automatic do_flush();
    step("flush", 1'b0, '0, 3'b000, 1'b1);
  endtask

  initial begin
    logic [DATA_W-1:0] va, vb, vc, vd, ve, vf, vg;
    va = 16'hA0A0; vb = 16'hB1B1; vc = 16'hC2C2; vd = 16'hD3D3;
    ve = 16'hE4E4; vf = 16'hF5F5; vg = 16'h1234;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; issue = '0; flush = 1'b0;
    #12;
    chk("rst_count", count, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_hvalid", head_valid, 0);
    chk("rst_hdata", head_data, 0);
    chk("rst_stall", stall_cnt, 0);
    rst = 1'b0;

    // Four in, nothing issued.
    step("a", 1'b1, va, 3'b000, 1'b0);
    step("b", 1'b1, vb, 3'b000, 1'b0);
    step("c", 1'b1, vc, 3'b000, 1'b0);
    step("d", 1'b1, vd, 3'b000, 1'b0);
    chk("fill4_count", count, 4);
    chk("fill4_hdata", head_data, {vc, vb, va});

    // Middle issue, then split issue around a survivor.
    step("e", 1'b1, ve, 3'b000, 1'b0);
    step("iss010", 1'b0, '0, 3'b010, 1'b0);
    chk("iss010_hdata", head_data, {vd, vc, va});
    chk("iss010_count", count, 4);
    step("iss101", 1'b0, '0, 3'b101, 1'b0);
    chk("iss101_hvalid", head_valid, 3'b011);
    chk("iss101_lo", head_data[2*DATA_W-1:0], {ve, vc});
    chk("iss101_count", count, 2);

    // Triple issue with a simultaneous enqueue.
    do_flush();
    step("a2", 1'b1, va, 3'b000, 1'b0);
    step("b2", 1'b1, vb, 3'b000, 1'b0);
    step("c2", 1'b1, vc, 3'b000, 1'b0);
    step("d2", 1'b1, vd, 3'b000, 1'b0);
    step("iss111", 1'b1, vf, 3'b111, 1'b0);
    chk("iss111_hvalid", head_valid, 3'b011);
    chk("iss111_lo", head_data[2*DATA_W-1:0], {vf, vd});
    chk("iss111_count", count, 2);

    // Full: issue does not open in_ready in the same cycle.
    do_flush();
    for (int k = 0; k < DEPTH; k++) step("fill8", 1'b1, 16'(k + 16'h0100), 3'b000, 1'b0);
    chk("full_ready", in_ready, 0);
    step("full_iss", 1'b1, vg, 3'b001, 1'b0);
    chk("full_iss_count", count, 7);
`ifdef IQ_STALL_CNT_EN
    chk("full_stall", stall_cnt, 1);
`endif
    step("full_acc", 1'b1, vg, 3'b000, 1'b0);
    chk("full_acc_count", count, 8);

    // Issue on an invalid slot is ignored.
    do_flush();
    step("two_a", 1'b1, va, 3'b000, 1'b0);
    step("two_b", 1'b1, vb, 3'b000, 1'b0);
    step("iss100", 1'b0, '0, 3'b100, 1'b0);
    chk("iss100_count", count, 2);

    // Flush beats issue and accept.
    for (int k = 0; k < 3; k++) step("five", 1'b1, 16'(k + 16'h0200), 3'b000, 1'b0);
    step("flush_all", 1'b1, vf, 3'b011, 1'b1);
    chk("flush_count", count, 0);
    chk("flush_hvalid", head_valid, 0);

    // Async reset mid-fill, checked before any clock edge.
    step("pre_rst_a", 1'b1, va, 3'b000, 1'b0);
    step("pre_rst_b", 1'b1, vb, 3'b000, 1'b0);
    in_valid = 1'b1; in_data = vc;
    #2 rst = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_hvalid", head_valid, 0);
    chk("arst_hdata", head_data, 0);
    mq.delete();
    mstall = 0;
    in_valid = 1'b0;
    #1 rst = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      logic       v, fl;
      logic [2:0] iss;
      v   = ($urandom_range(0, 9) < 7);
      iss = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      fl  = ($urandom_range(0, 99) == 0);
      step("rnd", v, 16'($urandom), iss, fl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iq_compact_ctrl.md
IQ_COMPACT_CTRL -- requirements
Module: iq_compact_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of queue entries (legal 4..16).
REQ-002 SHALL have parameter DATA_W, default 16, payload bits per entry.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  producer offers one entry this cycle.
REQ-006 SHALL have port in_data  input  DATA_W  payload of offered entry.
REQ-007 SHALL have port in_ready  output  1  queue accepts the offered entry this cycle.
REQ-008 SHALL have port head_valid  output  3  bit k = entry k holds a valid entry (entry 0 is the oldest).
REQ-009 SHALL have port head_data  output  3*DATA_W  payloads of entries 0..2; slice k = bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have port issue  input  3  bit k = entry k is issued (removed) this cycle.
REQ-011 SHALL have port flush  input  1  synchronous clear of all entries.
REQ-012 SHALL have port count  output  $clog2(DEPTH+1)  number of valid entries.
REQ-013 SHALL have port stall_cnt  output  16  saturating in-stall cycle count (see Configuration).

Function
REQ-014 SHALL keep valid entries packed contiguously from entry 0 at all times; no holes after any update.
REQ-015 SHALL ignore issue[k] when head_valid[k]=0.
REQ-016 SHALL on each edge remove every entry k with issue[k]&head_valid[k], and move each surviving entry j down by the number of removed entries with index < j (0..3 places).
REQ-017 SHALL compute the per-entry shift from the registered valid vector and the qualified issue vector only; the shift decode is internal, with no external shift inputs.
REQ-018 SHALL drive in_ready = (count < DEPTH), from registered state only, with no combinational path from issue or in_valid.
REQ-019 SHALL on in_valid&in_ready write in_data at index count - removed_this_cycle, after compaction, in the same edge.
REQ-020 SHALL update count as count + accept - removed each edge; simultaneous accept and removal SHALL be legal at every occupancy, including full and empty.
REQ-021 SHALL hold full at count=DEPTH: in_ready=0 even if issue frees entries this cycle; the freed space is usable next cycle.
REQ-022 SHALL on flush clear all valid bits and count next edge; flush SHALL override issue and accept in that cycle, and an offered entry is dropped (in_ready still reflects pre-flush state).
REQ-023 SHALL present head_valid/head_data directly from entry registers (zero-latency read); data of invalid entries is don't-care but SHALL NOT be X after reset.
REQ-024 SHALL keep the write index within 0..DEPTH-1 under all legal inputs; no wrap-around, since storage is a shifting array and not a ring.

Reset
REQ-025 SHALL on rst clear all valid bits and entry payloads to 0, count=0, stall_cnt=0; therefore in_ready=1 and head_valid=3'b000 immediately, asynchronously.
REQ-026 SHALL have rst asserted mid-operation discard all entries and take precedence over flush, issue and accept.

Configuration
REQ-027 SHALL have macro IQ_STALL_CNT_EN, which when defined compiles a 16-bit counter incremented each cycle in_valid&!in_ready, saturating at 16'hFFFF, cleared by rst and by flush.
REQ-028 SHALL have stall_cnt tied to 16'h0000 when IQ_STALL_CNT_EN is undefined, with no counter registers; all other behaviour is identical.

Verification
REQ-029 SHALL cover: after reset, enqueue A,B,C,D (DEPTH=8) with issue=0 -> count=4, head_valid=111, head_data={C,B,A}.
REQ-030 SHALL cover: entries A,B,C,D,E with issue=3'b010 -> next cycle head_data={D,C,A}, count=4; then issue=3'b101 -> head={-,E,C} with head_valid=011, count=2.
REQ-031 SHALL cover: entries A,B,C,D with issue=3'b111 plus enqueue F -> next cycle head_valid=011, head_data slices 0,1 = D,F, count=2.
REQ-032 SHALL cover: fill to 8 entries with in_valid held and issue=3'b001 -> in_ready=0 that cycle, count stays 8 then 7, and the offer is accepted the following cycle; with IQ_STALL_CNT_EN defined, stall_cnt=1.
REQ-033 SHALL cover: issue=3'b100 with only 2 valid entries -> no change, count unchanged.
REQ-034 SHALL cover: flush with in_valid=1 and issue=3'b011 at count=5 -> next cycle count=0, head_valid=000; rst asserted mid-fill -> outputs cleared without a clock edge.
